// File: rtl/traffic_phase_timer.sv
// -----------------------------------------------------------------------------
// traffic_phase_timer
//
// Interval timer serving the traffic light controller's phase timeouts. One
// shared counter restarts on every start strobe. Each expiry flag is a
// threshold compare of the registered count against that phase's duration.
//
// Ports:
//   clk         in   1      system clock, rising edge
//   sync_reset  in   1      synchronous active-high reset (priority over start)
//   start       in   1      restart request, level-sampled at the rising edge
//   tMG         out  1      count >= MG_CYCLES (main green expired)
//   tMY         out  1      count >= MY_CYCLES (main yellow expired)
//   tSG         out  1      count >= SG_CYCLES (side green expired)
//   tSY         out  1      count >= SY_CYCLES (side yellow expired)
//   busy        out  1      count < max of all *_CYCLES (some flag still low)
//   count       out  CNT_W  current counter value (observation)
//
// Valid/ready semantics: there is no handshake here. start is a level that is
// sampled every rising edge. The flags are plain levels derived from the
// registered counter, so the controller may consume a flag and assert start in
// the same cycle without losing a phase.
// -----------------------------------------------------------------------------
module traffic_phase_timer #(
    parameter int CNT_W     = 4,
    parameter int MG_CYCLES = 8,
    parameter int MY_CYCLES = 3,
    parameter int SG_CYCLES = 6,
    parameter int SY_CYCLES = 2
) (
    input  logic             clk,
    input  logic             sync_reset,
    input  logic             start,
    output logic             tMG,
    output logic             tMY,
    output logic             tSG,
    output logic             tSY,
    output logic             busy,
    output logic [CNT_W-1:0] count
);

    localparam int MAX_LEGAL = (1 << CNT_W) - 1;

    // Elaboration-time range check on every phase duration.
    generate
        if (CNT_W < 1 || CNT_W > 30) begin : g_bad_cnt_w
            $error("traffic_phase_timer: CNT_W out of range");
        end
        if (MG_CYCLES < 1 || MG_CYCLES > MAX_LEGAL) begin : g_bad_mg
            $error("traffic_phase_timer: MG_CYCLES out of range");
        end
        if (MY_CYCLES < 1 || MY_CYCLES > MAX_LEGAL) begin : g_bad_my
            $error("traffic_phase_timer: MY_CYCLES out of range");
        end
        if (SG_CYCLES < 1 || SG_CYCLES > MAX_LEGAL) begin : g_bad_sg
            $error("traffic_phase_timer: SG_CYCLES out of range");
        end
        if (SY_CYCLES < 1 || SY_CYCLES > MAX_LEGAL) begin : g_bad_sy
            $error("traffic_phase_timer: SY_CYCLES out of range");
        end
    endgenerate

    // Longest phase: busy stays high until its flag asserts.
    localparam int MAX_AB    = (MG_CYCLES > MY_CYCLES) ? MG_CYCLES : MY_CYCLES;
    localparam int MAX_CD    = (SG_CYCLES > SY_CYCLES) ? SG_CYCLES : SY_CYCLES;
    localparam int MAX_CYC   = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;

    localparam logic [CNT_W-1:0] MG_TH    = CNT_W'(MG_CYCLES);
    localparam logic [CNT_W-1:0] MY_TH    = CNT_W'(MY_CYCLES);
    localparam logic [CNT_W-1:0] SG_TH    = CNT_W'(SG_CYCLES);
    localparam logic [CNT_W-1:0] SY_TH    = CNT_W'(SY_CYCLES);
    localparam logic [CNT_W-1:0] MAX_TH   = CNT_W'(MAX_CYC);
    localparam logic [CNT_W-1:0] ALL_ONES = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Reset wins over start; both clear the count. Otherwise count up and
    // saturate at all-ones so an expired flag can never fall back to 0.
    always_comb begin
        cnt_d = cnt_q;
        if (sync_reset) begin
            cnt_d = '0;
        end else if (start) begin
            cnt_d = '0;
        end else if (cnt_q != ALL_ONES) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        cnt_q <= cnt_d;
    end

    // Flags come straight off the registered count: no extra latency.
    always_comb begin
        tMG   = (cnt_q >= MG_TH);
        tMY   = (cnt_q >= MY_TH);
        tSG   = (cnt_q >= SG_TH);
        tSY   = (cnt_q >= SY_TH);
        busy  = (cnt_q < MAX_TH);
        count = cnt_q;
    end

endmodule
